count_day: RTL and testbench



---
 rtl/count_day.sv | 88 ++++++++
 tb/tb_count_day.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/count_day.sv
// Day-of-month counter: advances on hour carry or set pulse, wraps by month
// length (leap-aware), clamps when the month shrinks under the current day,
// and emits a registered one-cycle carry to the month counter.
module count_day (
  input  logic       i_gclk,
  input  logic       i_grst,
  input  logic       i_count_day,
  input  logic       i_set_day,
  input  logic [3:0] i_morth,
  input  logic       i_leap_year,
  output logic [4:0] o_day,
  output logic [7:0] o_day_bcd,
  output logic       o_count_morth
);

  logic [4:0] r_day;
  logic [7:0] r_day_bcd;
  logic       r_count_morth;

  logic [4:0] w_dim;
  logic [4:0] w_day_nxt;
  logic       w_inc;
  logic       w_wrap;
  logic       w_carry_nxt;
  logic [3:0] w_tens;
  logic [3:0] w_units;
  logic [3:0] w_offs;

  // Days in the current month; invalid month codes behave as 31-day months.
  always_comb begin
    w_dim = 5'd31;
    case (i_morth)
      4'd1:                      w_dim = i_leap_year ? 5'd29 : 5'd28;
      4'd3, 4'd5, 4'd8, 4'd10:   w_dim = 5'd30;
      default:                   w_dim = 5'd31;
    endcase
  end

  // Next day: wrap beats +1 so the 5-bit sum never overflows; clamp only when idle.
  always_comb begin
    w_inc       = i_count_day | i_set_day;
    w_wrap      = (r_day >= w_dim);
    w_day_nxt   = r_day;
    w_carry_nxt = 1'b0;
    if (w_inc) begin
      w_day_nxt   = w_wrap ? 5'd1 : r_day + 5'd1;
      w_carry_nxt = i_count_day & w_wrap;
    end else if (r_day > w_dim) begin
      w_day_nxt = w_dim;
    end
  end

  // BCD of the next day; the units subtraction is done mod 16 since the
  // true remainder always fits in 4 bits (30 = 14 mod 16, 20 = 4 mod 16).
  always_comb begin
    w_tens = 4'd0;
    w_offs = 4'd0;
    if (w_day_nxt >= 5'd30) begin
      w_tens = 4'd3;
      w_offs = 4'd14;
    end else if (w_day_nxt >= 5'd20) begin
      w_tens = 4'd2;
      w_offs = 4'd4;
    end else if (w_day_nxt >= 5'd10) begin
      w_tens = 4'd1;
      w_offs = 4'd10;
    end
    w_units = w_day_nxt[3:0] - w_offs;
  end

  // State register; reset overrides any pulse or clamp in the same cycle.
  always_ff @(posedge i_gclk) begin
    if (i_grst) begin
      r_day         <= 5'd1;
      r_day_bcd     <= 8'h01;
      r_count_morth <= 1'b0;
    end else begin
      r_day         <= w_day_nxt;
      r_day_bcd     <= {w_tens, w_units};
      r_count_morth <= w_carry_nxt;
    end
  end

  assign o_day         = r_day;
  assign o_day_bcd     = r_day_bcd;
  assign o_count_morth = r_count_morth;

endmodule

// File: tb/tb_count_day.sv
// Bench for count_day: calendar-level reference model checked every cycle,
// plus directed literal checks that pin the model.
module tb_count_day;
  logic       clk;
  logic       rst;
  logic       cd;
  logic       sd;
  logic [3:0] morth;
  logic       leap;
  logic [4:0] day;
  logic [7:0] day_bcd;
  logic       carry;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  int m_day;
  bit m_carry;

  count_day dut (
    .i_gclk(clk), .i_grst(rst), .i_count_day(cd), .i_set_day(sd),
    .i_morth(morth), .i_leap_year(leap),
    .o_day(day), .o_day_bcd(day_bcd), .o_count_morth(carry)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic int month_len(input int m, input bit lp);
    int lens[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m > 11) return 31;
    if (m == 1 && lp) return 29;
    return lens[m];
  endfunction

  // Reference model: calendar rules applied to plain integers.
  always @(posedge clk) begin
    int d;
    d = month_len(int'(morth), leap);
    if (rst) begin
      m_day   <= 1;
      m_carry <= 0;
    end else if (cd || sd) begin
      m_day   <= (m_day >= d) ? 1 : m_day + 1;
      m_carry <= cd && (m_day >= d);
    end else begin
      m_day   <= (m_day > d) ? d : m_day;
      m_carry <= 0;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_day", int'(day), m_day);
      check("model_bcd", int'(day_bcd), ((m_day / 10) << 4) | (m_day % 10));
      check("model_carry", int'(carry), int'(m_carry));
    end
  end

  // Drive one cycle of inputs at a negedge, return at the next negedge.
  task automatic tick(input bit c, input bit s, input bit r);
    cd = c; sd = s; rst = r;
    @(negedge clk);
    cd = 0; sd = 0; rst = 0;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) tick(1, 0, 0);
  endtask

  initial begin
    rst = 1; cd = 1; sd = 0; morth = 0; leap = 0;
    @(negedge clk);
    // Reset held two cycles with count_day high.
    tick(1, 0, 1);
    chk_en = 1;
    check("rst_day", int'(day), 1);
    check("rst_bcd", int'(day_bcd), 'h01);
    check("rst_carry", int'(carry), 0);
    tick(1, 0, 1);
    check("rst2_day", int'(day), 1);
    check("rst2_carry", int'(carry), 0);

    // January wrap.
    pulses(30);
    check("jan_day31", int'(day), 31);
    check("jan_bcd31", int'(day_bcd), 'h31);
    tick(1, 0, 0);
    check("jan_wrap_day", int'(day), 1);
    check("jan_wrap_carry", int'(carry), 1);
    tick(0, 0, 0);
    check("jan_carry_drop", int'(carry), 0);

    // February, common year.
    morth = 1; leap = 0;
    pulses(27);
    check("feb_day28", int'(day), 28);
    tick(1, 0, 0);
    check("feb_wrap_day", int'(day), 1);
    check("feb_wrap_carry", int'(carry), 1);

    // February, leap year.
    leap = 1;
    pulses(27);
    tick(1, 0, 0);
    check("leap_day29", int'(day), 29);
    check("leap_no_carry", int'(carry), 0);
    tick(1, 0, 0);
    check("leap_wrap_day", int'(day), 1);
    check("leap_wrap_carry", int'(carry), 1);

    // April: count wrap, set wrap, simultaneous pulses.
    morth = 3; leap = 0;
    pulses(29);
    check("apr_day30", int'(day), 30);
    tick(1, 0, 0);
    check("apr_wrap_day", int'(day), 1);
    check("apr_wrap_carry", int'(carry), 1);
    pulses(29);
    tick(0, 1, 0);
    check("apr_set_wrap_day", int'(day), 1);
    check("apr_set_no_carry", int'(carry), 0);
    pulses(28);
    check("apr_day29", int'(day), 29);
    tick(1, 1, 0);
    check("apr_both_day", int'(day), 30);
    check("apr_both_bcd", int'(day_bcd), 'h30);

    // Clamp: day 31 then month set to April.
    morth = 0;
    tick(1, 0, 0);
    check("pre_clamp_day31", int'(day), 31);
    morth = 3;
    tick(0, 0, 0);
    check("clamp_apr_day", int'(day), 30);
    check("clamp_apr_bcd", int'(day_bcd), 'h30);
    check("clamp_apr_carry", int'(carry), 0);
    morth = 1; leap = 1;
    tick(0, 0, 0);
    check("clamp_feb_leap", int'(day), 29);
    leap = 0;
    tick(0, 0, 0);
    check("clamp_feb_common", int'(day), 28);
    check("clamp_feb_bcd", int'(day_bcd), 'h28);

    // Invalid month code behaves as 31 days.
    morth = 12;
    pulses(3);
    check("inv_day31", int'(day), 31);
    tick(1, 0, 0);
    check("inv_wrap_carry", int'(carry), 1);

    // Reset mid-operation at day 31 with a pending wrap.
    morth = 0;
    pulses(30);
    check("pre_rst_day31", int'(day), 31);
    tick(1, 0, 1);
    check("midrst_day", int'(day), 1);
    check("midrst_carry", int'(carry), 0);

    // Reset while carry is high drops it.
    pulses(30);
    tick(1, 0, 0);
    check("carry_hi", int'(carry), 1);
    tick(0, 0, 1);
    check("rst_drops_carry", int'(carry), 0);

    // Mixed pulses with month changes, model-checked only.
    for (int i = 0; i < 60; i++) begin
      morth = 4'(i % 14);
      leap  = (i % 3) == 0;
      tick((i % 2) == 0, (i % 5) == 0, 0);
    end
    tick(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
